noc_congestion_monitor: RTL and testbench



---
 rtl/noc_pkg.sv | 50 +++++
 rtl/noc_congestion_monitor_if.sv | 30 +++
 rtl/noc_cm_port.sv | 98 +++++++++
 rtl/noc_congestion_monitor.sv | 38 +++
 tb/tb_noc_congestion_monitor.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC types, port index macros and congestion monitor defaults
`ifndef EAST
`define EAST 0
`endif
`ifndef WEST
`define WEST 1
`endif
`ifndef NORTH
`define NORTH 2
`endif
`ifndef SOUTH
`define SOUTH 3
`endif

package noc_pkg;

  typedef struct packed {
    logic [1:0]  vc;
    logic        last;
    logic [31:0] data;
  } flit_t;

  typedef enum logic {
    CM_CLEAR = 1'b0,
    CM_CONG  = 1'b1
  } cm_state_t;

  localparam int CM_NP        = 4;
  localparam int CM_NV        = 2;
  localparam int CM_BUF_DEPTH = 4;
  localparam int CM_HI_THR    = 6;
  localparam int CM_LO_THR    = 3;
  localparam int CM_MIN_DWELL = 4;

  // Per-VC used-credit counter width: must hold 0..depth.
  function automatic int cm_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Per-port load width: must hold 0..nv*depth.
  function automatic int cm_tw(input int nv, input int depth);
    return $clog2(nv * depth + 1);
  endfunction

  // Dwell counter width; keep at least one bit so MIN_DWELL = 0 still elaborates.
  function automatic int cm_dw(input int dwell);
    return (dwell > 0) ? $clog2(dwell + 1) : 1;
  endfunction

endpackage

// File: rtl/noc_congestion_monitor_if.sv
// rtl/noc_congestion_monitor_if.sv - credit event inputs and congestion status outputs of the monitor
interface noc_congestion_monitor_if
  import noc_pkg::*;
#(
  parameter int NP        = CM_NP,
  parameter int NV        = CM_NV,
  parameter int BUF_DEPTH = CM_BUF_DEPTH
);
  localparam int TW = cm_tw(NV, BUF_DEPTH);

  logic                  en;
  logic [NP-1:0][NV-1:0] credit_consume;
  logic [NP-1:0][NV-1:0] credit_return;
  logic [NP-1:0][NV-1:0] credit_avail;
  logic [NP-1:0][TW-1:0] port_load;
  logic [NP-1:0]         congestion;
  logic [NP-1:0]         cred_err;

  // Router datapath side: reports credit events, consumes status.
  modport master (
    output en, credit_consume, credit_return,
    input  credit_avail, port_load, congestion, cred_err
  );

  // Monitor side.
  modport slave (
    input  en, credit_consume, credit_return,
    output credit_avail, port_load, congestion, cred_err
  );
endinterface

// File: rtl/noc_cm_port.sv
// rtl/noc_cm_port.sv - one output port: per-VC credit counters, load sum, hysteresis FSM with dwell
module noc_cm_port
  import noc_pkg::*;
#(
  parameter int NV        = CM_NV,
  parameter int BUF_DEPTH = CM_BUF_DEPTH,
  parameter int HI_THR    = CM_HI_THR,
  parameter int LO_THR    = CM_LO_THR,
  parameter int MIN_DWELL = CM_MIN_DWELL,
  localparam int CW       = cm_cw(BUF_DEPTH),
  localparam int TW       = cm_tw(NV, BUF_DEPTH),
  localparam int DW       = cm_dw(MIN_DWELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [NV-1:0] credit_consume,
  input  logic [NV-1:0] credit_return,
  output logic [NV-1:0] credit_avail,
  output logic [TW-1:0] port_load,
  output logic          congestion,
  output logic          cred_err
);

  logic [NV-1:0][CW-1:0] used_q, used_d;
  logic                  err_q, err_d;
  cm_state_t             state_q, state_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [TW-1:0]         load;

  // Counter update: simultaneous consume/return cancel; out-of-range events saturate and flag an error.
  always_comb begin
    used_d = used_q;
    err_d  = err_q;
    for (int v = 0; v < NV; v++) begin
      if (credit_consume[v] && !credit_return[v]) begin
        if (used_q[v] == CW'(BUF_DEPTH)) err_d = 1'b1;
        else                             used_d[v] = used_q[v] + 1'b1;
      end else if (credit_return[v] && !credit_consume[v]) begin
        if (used_q[v] == '0) err_d = 1'b1;
        else                 used_d[v] = used_q[v] - 1'b1;
      end
    end
  end

  // Availability and total load are taken from the registered counters.
  always_comb begin
    load = '0;
    for (int v = 0; v < NV; v++) begin
      credit_avail[v] = (used_q[v] < CW'(BUF_DEPTH));
      load            = load + TW'(used_q[v]);
    end
  end

  // Hysteresis FSM next state; every transition reloads the dwell timer, dropping enable bypasses it.
  always_comb begin
    state_d = state_q;
    dwell_d = (dwell_q != '0) ? dwell_q - 1'b1 : '0;
    case (state_q)
      CM_CLEAR: begin
        if (en && load >= TW'(HI_THR) && dwell_q == '0) begin
          state_d = CM_CONG;
          dwell_d = DW'(MIN_DWELL);
        end
      end
      CM_CONG: begin
        if (!en || (load <= TW'(LO_THR) && dwell_q == '0)) begin
          state_d = CM_CLEAR;
          dwell_d = DW'(MIN_DWELL);
        end
      end
      default: begin
        state_d = CM_CLEAR;
        dwell_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; traffic during reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q  <= '0;
      err_q   <= 1'b0;
      state_q <= CM_CLEAR;
      dwell_q <= '0;
    end else begin
      used_q  <= used_d;
      err_q   <= err_d;
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  assign port_load  = load;
  assign congestion = (state_q == CM_CONG);
  assign cred_err   = err_q;

endmodule

// File: rtl/noc_congestion_monitor.sv
// rtl/noc_congestion_monitor.sv - per-port credit congestion monitor feeding adaptive routing
module noc_congestion_monitor
  import noc_pkg::*;
#(
  parameter int NP        = CM_NP,
  parameter int NV        = CM_NV,
  parameter int BUF_DEPTH = CM_BUF_DEPTH,
  parameter int HI_THR    = CM_HI_THR,
  parameter int LO_THR    = CM_LO_THR,
  parameter int MIN_DWELL = CM_MIN_DWELL
) (
  input  logic                    clk,
  input  logic                    rst,
  noc_congestion_monitor_if.slave bus
);

  // Ports share nothing but clock, reset and enable.
  for (genvar p = 0; p < NP; p++) begin : g_port
    noc_cm_port #(
      .NV        (NV),
      .BUF_DEPTH (BUF_DEPTH),
      .HI_THR    (HI_THR),
      .LO_THR    (LO_THR),
      .MIN_DWELL (MIN_DWELL)
    ) u_port (
      .clk            (clk),
      .rst            (rst),
      .en             (bus.en),
      .credit_consume (bus.credit_consume[p]),
      .credit_return  (bus.credit_return[p]),
      .credit_avail   (bus.credit_avail[p]),
      .port_load      (bus.port_load[p]),
      .congestion     (bus.congestion[p]),
      .cred_err       (bus.cred_err[p])
    );
  end

endmodule

// File: tb/tb_noc_congestion_monitor.sv
// tb/tb_noc_congestion_monitor.sv - directed self-checking bench for noc_congestion_monitor
module tb_noc_congestion_monitor;
  import noc_pkg::*;

  localparam int NP        = 4;
  localparam int NV        = 2;
  localparam int BUF_DEPTH = 4;
  localparam int TW        = cm_tw(NV, BUF_DEPTH);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  noc_congestion_monitor_if #(.NP(NP), .NV(NV), .BUF_DEPTH(BUF_DEPTH)) bus ();

  noc_congestion_monitor #(
    .NP(NP), .NV(NV), .BUF_DEPTH(BUF_DEPTH),
    .HI_THR(6), .LO_THR(3), .MIN_DWELL(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP*NV-1:0] sel(input int p, input int v);
    logic [NP*NV-1:0] m;
    m = '0;
    m[p*NV+v] = 1'b1;
    return m;
  endfunction

  task automatic cyc(input logic [NP*NV-1:0] c, input logic [NP*NV-1:0] r);
    bus.credit_consume = c;
    bus.credit_return  = r;
    tick();
    bus.credit_consume = '0;
    bus.credit_return  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1;
    bus.credit_consume = '0;
    bus.credit_return  = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.port_load !== '0) begin errors++; $display("FAIL reset_load got=%h exp=0", bus.port_load); end
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL reset_cong got=%b exp=0000", bus.congestion); end
    checks++; if (bus.credit_avail !== 8'hff) begin errors++; $display("FAIL reset_avail got=%h exp=ff", bus.credit_avail); end
    checks++; if (bus.cred_err !== 4'b0000) begin errors++; $display("FAIL reset_err got=%b exp=0000", bus.cred_err); end
    for (int i = 0; i < 3; i++) cyc(sel(`EAST, 0), '0);
    for (int i = 0; i < 2; i++) cyc(sel(`EAST, 1), '0);
    checks++; if (bus.port_load[`EAST] !== TW'(5)) begin errors++; $display("FAIL midload_e got=%0d exp=5", bus.port_load[`EAST]); end
    rst = 1'b1;
    bus.credit_consume = sel(`EAST, 0) | sel(`WEST, 1);
    bus.credit_return  = sel(`EAST, 1);
    tick();
    rst = 1'b0;
    bus.credit_consume = '0;
    bus.credit_return  = '0;
    checks++; if (bus.port_load !== '0) begin errors++; $display("FAIL midrst_load got=%h exp=0", bus.port_load); end
    checks++; if (bus.credit_avail !== 8'hff) begin errors++; $display("FAIL midrst_avail got=%h exp=ff", bus.credit_avail); end
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL midrst_cong got=%b exp=0000", bus.congestion); end
    checks++; if (bus.cred_err !== 4'b0000) begin errors++; $display("FAIL midrst_err got=%b exp=0000", bus.cred_err); end
  endtask

  task automatic test_rising();
    for (int i = 0; i < 4; i++) cyc(sel(`EAST, 0), '0);
    checks++; if (bus.credit_avail[`EAST] !== 2'b10) begin errors++; $display("FAIL rise_avail got=%b exp=10", bus.credit_avail[`EAST]); end
    for (int i = 0; i < 2; i++) cyc(sel(`EAST, 1), '0);
    checks++; if (bus.port_load[`EAST] !== TW'(6)) begin errors++; $display("FAIL rise_load got=%0d exp=6", bus.port_load[`EAST]); end
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL rise_cong_e6 got=%b exp=0000", bus.congestion); end
    tick();
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL rise_cong_e7 got=%b exp=0001", bus.congestion); end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 2; i++) cyc('0, sel(`EAST, 1));
    checks++; if (bus.port_load[`EAST] !== TW'(4)) begin errors++; $display("FAIL hyst_load4 got=%0d exp=4", bus.port_load[`EAST]); end
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL hyst_hold4 got=%b exp=0001", bus.congestion); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL hyst_hold4_late got=%b exp=0001", bus.congestion); end
    cyc('0, sel(`EAST, 0));
    checks++; if (bus.port_load[`EAST] !== TW'(3)) begin errors++; $display("FAIL hyst_load3 got=%0d exp=3", bus.port_load[`EAST]); end
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL hyst_pre_clear got=%b exp=0001", bus.congestion); end
    tick();
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL hyst_clear got=%b exp=0000", bus.congestion); end
  endtask

  task automatic test_dwell();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(sel(`EAST, 0) | sel(`EAST, 1), '0);
    tick();
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL dwell_entry got=%b exp=0001", bus.congestion); end
    for (int i = 0; i < 3; i++) begin
      cyc('0, sel(`EAST, 0) | sel(`EAST, 1));
      checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL dwell_hold%0d got=%b exp=0001", i, bus.congestion); end
    end
    checks++; if (bus.port_load[`EAST] !== TW'(0)) begin errors++; $display("FAIL dwell_load0 got=%0d exp=0", bus.port_load[`EAST]); end
    tick();
    checks++; if (bus.congestion !== 4'b0001) begin errors++; $display("FAIL dwell_hold_last got=%b exp=0001", bus.congestion); end
    tick();
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL dwell_clear got=%b exp=0000", bus.congestion); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 2; i++) cyc(sel(`NORTH, 1), '0);
    checks++; if (bus.port_load[`NORTH] !== TW'(2)) begin errors++; $display("FAIL sim_load2 got=%0d exp=2", bus.port_load[`NORTH]); end
    cyc(sel(`NORTH, 1), sel(`NORTH, 1));
    checks++; if (bus.port_load[`NORTH] !== TW'(2)) begin errors++; $display("FAIL sim_both got=%0d exp=2", bus.port_load[`NORTH]); end
    for (int i = 0; i < 2; i++) cyc(sel(`NORTH, 1), '0);
    checks++; if (bus.credit_avail[`NORTH] !== 2'b01) begin errors++; $display("FAIL sim_avail got=%b exp=01", bus.credit_avail[`NORTH]); end
    checks++; if (bus.cred_err !== 4'b0000) begin errors++; $display("FAIL sim_noerr got=%b exp=0000", bus.cred_err); end
    cyc(sel(`NORTH, 1), '0);
    checks++; if (bus.port_load[`NORTH] !== TW'(4)) begin errors++; $display("FAIL sim_sat got=%0d exp=4", bus.port_load[`NORTH]); end
    checks++; if (bus.cred_err !== 4'b0100) begin errors++; $display("FAIL sim_ovf got=%b exp=0100", bus.cred_err); end
    tick();
    checks++; if (bus.cred_err !== 4'b0100) begin errors++; $display("FAIL sim_sticky got=%b exp=0100", bus.cred_err); end
    cyc('0, sel(`SOUTH, 0));
    checks++; if (bus.cred_err !== 4'b1100) begin errors++; $display("FAIL sim_udf got=%b exp=1100", bus.cred_err); end
    checks++; if (bus.port_load[`SOUTH] !== TW'(0)) begin errors++; $display("FAIL sim_udf_load got=%0d exp=0", bus.port_load[`SOUTH]); end
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL sim_cong got=%b exp=0000", bus.congestion); end
  endtask

  task automatic test_enable();
    do_reset();
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) cyc(sel(`WEST, 0) | sel(`WEST, 1), '0);
    checks++; if (bus.port_load[`WEST] !== TW'(8)) begin errors++; $display("FAIL en_load8 got=%0d exp=8", bus.port_load[`WEST]); end
    checks++; if (bus.credit_avail[`WEST] !== 2'b00) begin errors++; $display("FAIL en_avail got=%b exp=00", bus.credit_avail[`WEST]); end
    tick();
    tick();
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL en_off_cong got=%b exp=0000", bus.congestion); end
    bus.en = 1'b1;
    tick();
    tick();
    checks++; if (bus.congestion !== 4'b0010) begin errors++; $display("FAIL en_on_cong got=%b exp=0010", bus.congestion); end
    bus.en = 1'b0;
    tick();
    checks++; if (bus.congestion !== 4'b0000) begin errors++; $display("FAIL en_drop_cong got=%b exp=0000", bus.congestion); end
    bus.en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rising();
    test_hysteresis();
    test_dwell();
    test_simultaneous();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
